dmem_arbiter: RTL and testbench

- Shares the single-port data RAM (12-bit word address, 32-bit data, registered read, 1-cycle latency) between two requesters.
- Port 0 is the processor's load/store path. Port 1 is the sonar capture/DMA engine that writes echo timings and reads configuration words.
- Grants in the same cycle, stalls the losing requester, and routes read data back with a per-port valid strobe.
- Sits between the processor's memory interface and the RAM instance in the FPGA top.

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arb_pick.sv | 62 ++++++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: bus widths, port ids and the
// pending-read record carried from a read grant to its data return.
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_W = 12;
    localparam int unsigned DMEM_DATA_W = 32;

    // Widths of the starvation and burst counters
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned BURST_W = 4;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_DMA = 1'b1;

    // One outstanding read: which port owns the data arriving next cycle
    typedef struct packed {
        logic     valid;
        port_id_t port;
    } pend_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the data-memory arbiter.
// Resolution order: burst lock, then starvation guard, then the contention policy
// (fixed port-0 priority, or round-robin when DMEM_ARB_RR_EN is defined).
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               en_i,
    input  logic               req0_i,
    input  logic               req1_i,
    input  logic               lock1_i,
    input  logic               gnt1_prev_i,
    input  logic [WAIT_W-1:0]  wait_cnt_i,
    input  logic [BURST_W-1:0] burst_cnt_i,
`ifdef DMEM_ARB_RR_EN
    input  port_id_t           last_winner_i,
`endif
    output logic               gnt0_o,
    output logic               gnt1_o,
    output logic               locked_o
);

    localparam logic [WAIT_W-1:0]  WaitMax   = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BurstLast = BURST_W'(MAX_BURST - 1);

    logic lock_hold;
    logic starve;

    // Pick at most one winner; en_i low forces no grant
    always_comb begin
        gnt0_o   = 1'b0;
        gnt1_o   = 1'b0;
        locked_o = 1'b0;
        // The last permitted burst beat releases the lock for one arbitration
        lock_hold = gnt1_prev_i && lock1_i && req1_i && (burst_cnt_i != BurstLast);
        starve    = req1_i && (wait_cnt_i == WaitMax);
        if (en_i) begin
            if (lock_hold) begin
                gnt1_o   = 1'b1;
                locked_o = 1'b1;
            end else if (starve) begin
                gnt1_o = 1'b1;
            end else if (req0_i && req1_i) begin
`ifdef DMEM_ARB_RR_EN
                if (last_winner_i == PORT_CPU) begin
                    gnt1_o = 1'b1;
                end else begin
                    gnt0_o = 1'b1;
                end
`else
                gnt0_o = 1'b1;
`endif
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: processor (port 0) and
// sonar DMA (port 1). Grants are combinational; read data returns one cycle after
// the grant with a per-port valid strobe.
// Optional build macro DMEM_ARB_RR_EN replaces fixed port-0 priority on contention
// with round-robin via a last_winner register.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   req0,
    input  logic                   we0,
    input  logic [DMEM_ADDR_W-1:0] addr0,
    input  logic [DMEM_DATA_W-1:0] wdata0,
    output logic                   gnt0,
    output logic                   stall0,
    output logic                   rvalid0,
    output logic [DMEM_DATA_W-1:0] rdata0,
    input  logic                   req1,
    input  logic                   we1,
    input  logic [DMEM_ADDR_W-1:0] addr1,
    input  logic [DMEM_DATA_W-1:0] wdata1,
    input  logic                   lock1,
    output logic                   gnt1,
    output logic                   rvalid1,
    output logic [DMEM_DATA_W-1:0] rdata1,
    output logic                   ram_we,
    output logic [DMEM_ADDR_W-1:0] ram_addr,
    output logic [DMEM_DATA_W-1:0] ram_wdata,
    input  logic [DMEM_DATA_W-1:0] ram_q
);

    localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MAX_WAIT);

    logic arb_gnt0;
    logic arb_gnt1;
    logic arb_locked;

    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic                   gnt1_q, gnt1_d;
    pend_t                  pend_q, pend_d;
    logic [DMEM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DMEM_DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DMEM_DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DMEM_DATA_W-1:0] rdata1_q, rdata1_d;

`ifdef DMEM_ARB_RR_EN
    port_id_t last_winner_q, last_winner_d;
`endif

    dmem_arb_pick #(
        .MAX_WAIT  (MAX_WAIT),
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .en_i          (resetn),
        .req0_i        (req0),
        .req1_i        (req1),
        .lock1_i       (lock1),
        .gnt1_prev_i   (gnt1_q),
        .wait_cnt_i    (wait_cnt_q),
        .burst_cnt_i   (burst_cnt_q),
`ifdef DMEM_ARB_RR_EN
        .last_winner_i (last_winner_q),
`endif
        .gnt0_o        (arb_gnt0),
        .gnt1_o        (arb_gnt1),
        .locked_o      (arb_locked)
    );

    // RAM drive from the granted port (address/data hold when idle) and read return
    always_comb begin
        gnt0        = arb_gnt0;
        gnt1        = arb_gnt1;
        stall0      = resetn && req0 && !arb_gnt0;
        ram_we      = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (arb_gnt0) begin
            ram_we      = we0;
            ram_addr_d  = addr0;
            ram_wdata_d = wdata0;
        end else if (arb_gnt1) begin
            ram_we      = we1;
            ram_addr_d  = addr1;
            ram_wdata_d = wdata1;
        end
        ram_addr  = ram_addr_d;
        ram_wdata = ram_wdata_d;

        // Gating with resetn drops a read that was pending when reset hit
        rvalid0  = resetn && pend_q.valid && (pend_q.port == PORT_CPU);
        rvalid1  = resetn && pend_q.valid && (pend_q.port == PORT_DMA);
        rdata0_d = rvalid0 ? ram_q : rdata0_q;
        rdata1_d = rvalid1 ? ram_q : rdata1_q;
        rdata0   = rdata0_d;
        rdata1   = rdata1_d;
    end

    // Next state for starvation/burst counters and the pending-read record
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1 || arb_gnt1) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        // Only grants won through the lock extend the burst; a fresh grant restarts it
        burst_cnt_d = arb_locked ? burst_cnt_q + 1'b1 : '0;
        gnt1_d      = arb_gnt1;

        pend_d.valid = (arb_gnt0 && !we0) || (arb_gnt1 && !we1);
        pend_d.port  = arb_gnt1 ? PORT_DMA : PORT_CPU;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            gnt1_q      <= 1'b0;
            pend_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            gnt1_q      <= gnt1_d;
            pend_q      <= pend_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember the most recent winner for round-robin contention
    always_comb begin
        last_winner_d = last_winner_q;
        if (arb_gnt0) begin
            last_winner_d = PORT_CPU;
        end else if (arb_gnt1) begin
            last_winner_d = PORT_DMA;
        end
    end

    // Reset to DMA so the first contended cycle goes to the processor
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_winner_q <= PORT_DMA;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed port commands, expected grants and
// read returns queued up front, a monitor pops and compares as the DUT responds.
module tb_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } cmd_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        stall0;
    } gexp_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rexp_t;

    logic        clock;
    logic        resetn;
    logic        req0, we0, gnt0, stall0, rvalid0;
    logic [11:0] addr0;
    logic [31:0] wdata0, rdata0;
    logic        req1, we1, lock1, gnt1, rvalid1;
    logic [11:0] addr1;
    logic [31:0] wdata1, rdata1;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata, ram_q;

    logic [31:0] mem [4096];

    cmd_t  q0[$];
    cmd_t  q1[$];
    gexp_t eq[$];
    rexp_t rq[$];

    int n_vec;
    int n_err;

    dmem_arbiter #(
        .MAX_WAIT  (8),
        .MAX_BURST (4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .stall0    (stall0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .lock1     (lock1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_q     (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM with registered read
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic port, input logic we, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic lock);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.lock = lock;
        if (port) q1.push_back(c);
        else q0.push_back(c);
    endtask

    task automatic push_g(input logic port, input logic we, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic stall);
        gexp_t g;
        g.port = port; g.we = we; g.addr = addr; g.wdata = wdata; g.stall0 = stall;
        eq.push_back(g);
    endtask

    task automatic push_r(input logic port, input logic [31:0] data);
        rexp_t r;
        r.port = port; r.data = data;
        rq.push_back(r);
    endtask

    // Wait until every command is granted; an expired budget is a failure
    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((eq.size() > 0 || q0.size() > 0 || q1.size() > 0) && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (k >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d grants still outstanding, expected 0", eq.size());
        end
    endtask

    // Requester agents: hold each command until granted, then present the next
    initial begin : agent
        logic g0, g1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;
        forever begin
            @(negedge clock);
            g0 = req0 && gnt0;
            g1 = req1 && gnt1;
            @(posedge clock);
            #1;
            if (g0 && q0.size() > 0) void'(q0.pop_front());
            if (g1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
            end else begin
                req0 = 1'b0; we0 = 1'b0;
            end
            if (q1.size() > 0) begin
                req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
                lock1 = q1[0].lock;
            end else begin
                req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
            end
        end
    end

    // Monitor: compare every grant and every read return against the queues
    initial begin : monitor
        gexp_t g;
        rexp_t r;
        logic  pend_v;
        logic  pend_p;
        pend_v = 1'b0;
        pend_p = 1'b0;
        forever begin
            @(negedge clock);
            if (rvalid0 || rvalid1) begin
                check1("rvalid_onehot", rvalid0 && rvalid1, 1'b0);
                check1("rvalid_latency", pend_v, 1'b1);
                check1("rvalid_port_vs_grant", rvalid1, pend_p);
                if (rq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rvalid: rvalid0=%b rvalid1=%b expected none",
                             rvalid0, rvalid1);
                end else begin
                    r = rq.pop_front();
                    check1("rvalid_port", rvalid1, r.port);
                    check32("rdata", rvalid1 ? rdata1 : rdata0, r.data);
                end
            end
            pend_v = 1'b0;
            if (gnt0 || gnt1) begin
                check1("gnt_onehot", gnt0 && gnt1, 1'b0);
                if (eq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_grant: gnt0=%b gnt1=%b expected none", gnt0, gnt1);
                end else begin
                    g = eq.pop_front();
                    check1("gnt_port", gnt1, g.port);
                    check1("ram_we", ram_we, g.we);
                    check32("ram_addr", {20'b0, ram_addr}, {20'b0, g.addr});
                    if (g.we) check32("ram_wdata", ram_wdata, g.wdata);
                    check1("stall0", stall0, g.stall0);
                    pend_v = !g.we;
                    pend_p = g.port;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        #2;

        // Both ports queue 10 writes while reset holds them off
        for (int i = 0; i < 10; i++) begin
            cmd(1'b0, 1'b1, 12'(32'h100 + i), 32'hA000_0000 + 32'(i), 1'b0);
            cmd(1'b1, 1'b1, 12'(32'h200 + i), 32'hB000_0000 + 32'(i), 1'b0);
        end
`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 10; i++) begin
            push_g(1'b0, 1'b1, 12'(32'h100 + i), 32'hA000_0000 + 32'(i), 1'b0);
            push_g(1'b1, 1'b1, 12'(32'h200 + i), 32'hB000_0000 + 32'(i), (i < 9));
        end
`else
        for (int i = 0; i < 8; i++)
            push_g(1'b0, 1'b1, 12'(32'h100 + i), 32'hA000_0000 + 32'(i), 1'b0);
        push_g(1'b1, 1'b1, 12'h200, 32'hB000_0000, 1'b1);
        push_g(1'b0, 1'b1, 12'h108, 32'hA000_0008, 1'b0);
        push_g(1'b0, 1'b1, 12'h109, 32'hA000_0009, 1'b0);
        for (int i = 1; i < 10; i++)
            push_g(1'b1, 1'b1, 12'(32'h200 + i), 32'hB000_0000 + 32'(i), 1'b0);
`endif

        repeat (3) @(negedge clock);
        check1("reset_req_seen", req0 && req1, 1'b1);
        check1("reset_gnt0", gnt0, 1'b0);
        check1("reset_gnt1", gnt1, 1'b0);
        check1("reset_stall0", stall0, 1'b0);
        check1("reset_ram_we", ram_we, 1'b0);
        check1("reset_rvalid0", rvalid0, 1'b0);
        check1("reset_rvalid1", rvalid1, 1'b0);
        check32("reset_ram_addr", {20'b0, ram_addr}, 32'h0);
        check32("reset_ram_wdata", ram_wdata, 32'h0);
        check32("reset_rdata0", rdata0, 32'h0);
        check32("reset_rdata1", rdata1, 32'h0);

        @(posedge clock);
        #1;
        resetn = 1'b1;
        drain(200);
        repeat (2) @(negedge clock);

        // Write via port 1, read back via port 0
        #2;
        cmd(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0);
        push_g(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0);
        drain(20);
        #2;
        cmd(1'b0, 1'b0, 12'h010, 32'h0, 1'b0);
        push_g(1'b0, 1'b0, 12'h010, 32'h0, 1'b0);
        push_r(1'b0, 32'hDEAD_BEEF);
        drain(20);
        repeat (2) @(negedge clock);
        check1("idle_ram_we", ram_we, 1'b0);
        check32("idle_ram_addr_hold", {20'b0, ram_addr}, 32'h010);

        // Contended reads from both ports
        #2;
        cmd(1'b0, 1'b0, 12'h100, 32'h0, 1'b0);
        cmd(1'b0, 1'b0, 12'h101, 32'h0, 1'b0);
        cmd(1'b1, 1'b0, 12'h200, 32'h0, 1'b0);
`ifdef DMEM_ARB_RR_EN
        push_g(1'b1, 1'b0, 12'h200, 32'h0, 1'b1);
        push_g(1'b0, 1'b0, 12'h100, 32'h0, 1'b0);
        push_g(1'b0, 1'b0, 12'h101, 32'h0, 1'b0);
        push_r(1'b1, 32'hB000_0000);
        push_r(1'b0, 32'hA000_0000);
        push_r(1'b0, 32'hA000_0001);
`else
        push_g(1'b0, 1'b0, 12'h100, 32'h0, 1'b0);
        push_g(1'b0, 1'b0, 12'h101, 32'h0, 1'b0);
        push_g(1'b1, 1'b0, 12'h200, 32'h0, 1'b0);
        push_r(1'b0, 32'hA000_0000);
        push_r(1'b0, 32'hA000_0001);
        push_r(1'b1, 32'hB000_0000);
`endif
        drain(20);
        repeat (3) @(negedge clock);

        // Locked burst of six port-1 reads; port 0 joins one cycle later
        #2;
        for (int i = 0; i < 6; i++)
            cmd(1'b1, 1'b0, 12'(32'h200 + i), 32'h0, 1'b1);
        for (int i = 0; i < 4; i++)
            push_g(1'b1, 1'b0, 12'(32'h200 + i), 32'h0, (i > 0));
        push_g(1'b0, 1'b0, 12'h102, 32'h0, 1'b0);
        push_g(1'b1, 1'b0, 12'h204, 32'h0, 1'b0);
        push_g(1'b1, 1'b0, 12'h205, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            push_r(1'b1, 32'hB000_0000 + 32'(i));
        push_r(1'b0, 32'hA000_0002);
        push_r(1'b1, 32'hB000_0004);
        push_r(1'b1, 32'hB000_0005);
        @(negedge clock);
        #2;
        cmd(1'b0, 1'b0, 12'h102, 32'h0, 1'b0);
        drain(40);
        repeat (3) @(negedge clock);
        check32("rdata0_hold", rdata0, 32'hA000_0002);
        check32("rdata1_hold", rdata1, 32'hB000_0005);

        // Reset in the cycle after a read grant: the return must never appear
        #2;
        cmd(1'b0, 1'b0, 12'h010, 32'h0, 1'b0);
        push_g(1'b0, 1'b0, 12'h010, 32'h0, 1'b0);
        k = 0;
        while (!gnt0 && k < 20) begin
            @(negedge clock);
            k++;
        end
        check1("midread_grant_seen", gnt0, 1'b1);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check1("midread_rvalid0", rvalid0, 1'b0);
            check1("midread_rvalid1", rvalid1, 1'b0);
        end
        @(posedge clock);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check1("postreset_rvalid0", rvalid0, 1'b0);
            check32("postreset_rdata0", rdata0, 32'h0);
            check32("postreset_ram_addr", {20'b0, ram_addr}, 32'h0);
        end

        check32("grants_left", 32'(eq.size()), 32'h0);
        check32("reads_left", 32'(rq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
